tlc_phase_scheduler: RTL

Phase sequencer for the traffic light controller. Steps three signal phases (A = main road dir 1, B = main road dir 2, C = side road) through green, yellow and all-red clearance. Selects peak or off-peak green lengths and skips the side road when it has no demand. Supports emergency-vehicle preemption with a req/ack handshake. Sits between the timebase/sensor front end and the light drivers. Its per-phase light codes feed the TL1–TL6 output mapping.

---
 rtl/tlc_phase_scheduler_if.sv | 26 ++
 rtl/tlc_phase_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_phase_scheduler_if.sv
// Signal bundle between the timebase/sensor front end and the phase scheduler.
// The front end (master) drives timing, mode and preemption requests; the
// scheduler (slave) returns the per-phase light codes and status.
interface tlc_phase_scheduler_if;
    logic       tick;
    logic       peak;
    logic       sensor_c;
    logic       preempt_req;
    logic [1:0] preempt_phase;
    logic [1:0] tl_a;
    logic [1:0] tl_b;
    logic [1:0] tl_c;
    logic [1:0] active_phase;
    logic       phase_start;
    logic       preempt_ack;

    modport master (
        output tick, peak, sensor_c, preempt_req, preempt_phase,
        input  tl_a, tl_b, tl_c, active_phase, phase_start, preempt_ack
    );

    modport slave (
        input  tick, peak, sensor_c, preempt_req, preempt_phase,
        output tl_a, tl_b, tl_c, active_phase, phase_start, preempt_ack
    );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Phase sequencer: steps phases A, B, C through green, yellow and all-red,
// picks peak/off-peak green lengths, skips the side road without demand and
// handles emergency preemption with a req/ack handshake. All outputs are
// registered from the next-state decode.
module tlc_phase_scheduler #(
    parameter int G_PEAK_A = 32,
    parameter int G_PEAK_B = 32,
    parameter int G_PEAK_C = 16,
    parameter int G_OFF_A  = 16,
    parameter int G_OFF_B  = 16,
    parameter int G_OFF_C  = 8,
    parameter int Y_TIME   = 4,
    parameter int R_TIME   = 2,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    tlc_phase_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] PH_A    = 2'd0;
    localparam logic [1:0] PH_B    = 2'd1;
    localparam logic [1:0] PH_C    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    localparam logic [1:0] TL_GREEN  = 2'd0;
    localparam logic [1:0] TL_YELLOW = 2'd1;
    localparam logic [1:0] TL_RED    = 2'd2;

    // Lengths are stored as (length - 1) so the terminal test is a plain compare.
    localparam logic [CNT_W-1:0] LEN_PEAK_A_M1 = CNT_W'(G_PEAK_A - 1);
    localparam logic [CNT_W-1:0] LEN_PEAK_B_M1 = CNT_W'(G_PEAK_B - 1);
    localparam logic [CNT_W-1:0] LEN_PEAK_C_M1 = CNT_W'(G_PEAK_C - 1);
    localparam logic [CNT_W-1:0] LEN_OFF_A_M1  = CNT_W'(G_OFF_A - 1);
    localparam logic [CNT_W-1:0] LEN_OFF_B_M1  = CNT_W'(G_OFF_B - 1);
    localparam logic [CNT_W-1:0] LEN_OFF_C_M1  = CNT_W'(G_OFF_C - 1);
    localparam logic [CNT_W-1:0] LEN_Y_M1      = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] LEN_R_M1      = CNT_W'(R_TIME - 1);

    function automatic logic [CNT_W-1:0] green_len_m1(input logic [1:0] ph, input logic pk);
        logic [CNT_W-1:0] len_m1;
        case (ph)
            PH_B:    len_m1 = pk ? LEN_PEAK_B_M1 : LEN_OFF_B_M1;
            PH_C:    len_m1 = pk ? LEN_PEAK_C_M1 : LEN_OFF_C_M1;
            default: len_m1 = pk ? LEN_PEAK_A_M1 : LEN_OFF_A_M1;
        endcase
        return len_m1;
    endfunction

    // Registered state
    state_t           r_state;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len_m1;
    logic             r_demand_c;
    logic             r_pend;
    logic [1:0]       r_target;
    logic [1:0]       r_tl_a;
    logic [1:0]       r_tl_b;
    logic [1:0]       r_tl_c;
    logic             r_phase_start;
    logic             r_preempt_ack;

    // Next-state values
    state_t           w_state;
    logic [1:0]       w_phase;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_len_m1;
    logic             w_demand_c;
    logic             w_pend;
    logic [1:0]       w_target;
    logic [1:0]       w_tl_a;
    logic [1:0]       w_tl_b;
    logic [1:0]       w_tl_c;
    logic             w_phase_start;
    logic             w_preempt_ack;

    // Helpers
    logic             w_pre_valid;
    logic [1:0]       w_pre_target;
    logic [CNT_W-1:0] w_limit;
    logic             w_done;
    logic [1:0]       w_succ;
    logic             w_enter_green_c;

    // Preemption request tracking: a request counts on the very edge it is
    // first seen, the target is frozen while pending, and dropping the
    // request at any point cancels it.
    always_comb begin
        w_pre_valid  = bus.preempt_req && (r_pend || (bus.preempt_phase != PH_NONE));
        w_pre_target = r_pend ? r_target : bus.preempt_phase;
        w_pend       = w_pre_valid;
        w_target     = w_pre_valid ? w_pre_target : r_target;
    end

    // Interval terminal count and the normal phase successor.
    always_comb begin
        case (r_state)
            S_YELLOW: w_limit = LEN_Y_M1;
            S_ALLRED: w_limit = LEN_R_M1;
            default:  w_limit = r_len_m1;
        endcase
        w_done = (r_cnt == w_limit);

        case (r_phase)
            PH_A:    w_succ = PH_B;
            PH_B:    w_succ = (bus.peak || r_demand_c) ? PH_C : PH_A;
            default: w_succ = PH_A;
        endcase
    end

    // Next-state logic for the phase FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state         = r_state;
        w_phase         = r_phase;
        w_cnt           = r_cnt;
        w_len_m1        = r_len_m1;
        w_phase_start   = 1'b0;
        w_enter_green_c = 1'b0;

        case (r_state)
            S_GREEN: begin
                if (w_pre_valid) begin
                    // Same-phase preemption holds the green without a new start.
                    w_cnt   = '0;
                    w_state = (w_pre_target == r_phase) ? S_HOLD : S_YELLOW;
                end else if (bus.tick) begin
                    if (w_done) begin
                        w_cnt   = '0;
                        w_state = S_YELLOW;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_YELLOW: begin
                if (bus.tick) begin
                    if (w_done) begin
                        w_cnt   = '0;
                        w_state = S_ALLRED;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_ALLRED: begin
                if (bus.tick) begin
                    if (w_done) begin
                        w_cnt         = '0;
                        w_phase_start = 1'b1;
                        if (w_pre_valid) begin
                            w_state = S_HOLD;
                            w_phase = w_pre_target;
                        end else begin
                            w_state         = S_GREEN;
                            w_phase         = w_succ;
                            w_len_m1        = green_len_m1(w_succ, bus.peak);
                            w_enter_green_c = (w_succ == PH_C);
                        end
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                // HOLD: counter frozen until the request is released.
                if (!bus.preempt_req) begin
                    w_cnt   = '0;
                    w_state = S_YELLOW;
                end
            end
        endcase

        // A sensor hit on the same edge as C's green entry keeps the demand.
        w_demand_c = bus.sensor_c || (r_demand_c && !w_enter_green_c);
    end

    // Light codes and ack decoded from the next state so they register cleanly.
    always_comb begin
        w_tl_a        = TL_RED;
        w_tl_b        = TL_RED;
        w_tl_c        = TL_RED;
        w_preempt_ack = (w_state == S_HOLD);
        if (w_state != S_ALLRED) begin
            case (w_phase)
                PH_A:    w_tl_a = (w_state == S_YELLOW) ? TL_YELLOW : TL_GREEN;
                PH_B:    w_tl_b = (w_state == S_YELLOW) ? TL_YELLOW : TL_GREEN;
                default: w_tl_c = (w_state == S_YELLOW) ? TL_YELLOW : TL_GREEN;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!reset) begin
            r_state       <= S_GREEN;
            r_phase       <= PH_A;
            r_cnt         <= '0;
            r_len_m1      <= green_len_m1(PH_A, bus.peak);
            r_demand_c    <= 1'b0;
            r_pend        <= 1'b0;
            r_target      <= PH_A;
            r_tl_a        <= TL_GREEN;
            r_tl_b        <= TL_RED;
            r_tl_c        <= TL_RED;
            r_phase_start <= 1'b0;
            r_preempt_ack <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_phase       <= w_phase;
            r_cnt         <= w_cnt;
            r_len_m1      <= w_len_m1;
            r_demand_c    <= w_demand_c;
            r_pend        <= w_pend;
            r_target      <= w_target;
            r_tl_a        <= w_tl_a;
            r_tl_b        <= w_tl_b;
            r_tl_c        <= w_tl_c;
            r_phase_start <= w_phase_start;
            r_preempt_ack <= w_preempt_ack;
        end
    end

    assign bus.tl_a         = r_tl_a;
    assign bus.tl_b         = r_tl_b;
    assign bus.tl_c         = r_tl_c;
    assign bus.active_phase = r_phase;
    assign bus.phase_start  = r_phase_start;
    assign bus.preempt_ack  = r_preempt_ack;

endmodule
